branch_predictor: RTL and testbench

- Fetch-side counterpart of the execute-stage branch resolver.
- Predicts taken/not-taken for each fetched control-transfer instruction using a bimodal table of 2-bit saturating counters.
- Trains the table from resolved outcomes returned by execute and flags mispredictions so fetch can flush and redirect.
- Sits between the fetch PC register and the execute-stage resolution logic.

---
 rtl/branch_predictor_pkg.sv | 32 +++
 rtl/branch_predictor_if.sv | 42 ++++
 rtl/branch_predictor_bht_counter_update.sv | 24 ++
 rtl/branch_predictor.sv | 149 ++++++++++++++
 tb/tb_branch_predictor.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ==========================================================================
// branch_predictor_pkg : opcodes, counter encodings and FSM states shared
//                        by the predictor and the execute-stage resolver.
// Rev 1.0
// ==========================================================================
package branch_predictor_pkg;

  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic is_jump(input logic [4:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ==========================================================================
// branch_predictor_if : fetch prediction and execute resolution signals.
// Rev 1.0
// ==========================================================================
interface branch_predictor_if;

  logic        pred_req_in;
  logic [31:0] pred_pc_in;
  logic [4:0]  pred_opcode_6_to_2_in;
  logic        pred_valid_out;
  logic        pred_taken_out;

  logic        res_valid_in;
  logic [31:0] res_pc_in;
  logic [4:0]  res_opcode_6_to_2_in;
  logic        res_taken_in;
  logic        res_pred_taken_in;

  logic        mispredict_out;
  logic        ready_out;
  logic [31:0] branch_count_out;
  logic [31:0] mispredict_count_out;

  modport master (
    output pred_req_in, pred_pc_in, pred_opcode_6_to_2_in,
    output res_valid_in, res_pc_in, res_opcode_6_to_2_in,
    output res_taken_in, res_pred_taken_in,
    input  pred_valid_out, pred_taken_out, mispredict_out, ready_out,
    input  branch_count_out, mispredict_count_out
  );

  modport slave (
    input  pred_req_in, pred_pc_in, pred_opcode_6_to_2_in,
    input  res_valid_in, res_pc_in, res_opcode_6_to_2_in,
    input  res_taken_in, res_pred_taken_in,
    output pred_valid_out, pred_taken_out, mispredict_out, ready_out,
    output branch_count_out, mispredict_count_out
  );

endinterface
`default_nettype wire

// File: rtl/branch_predictor_bht_counter_update.sv
`default_nettype none
// ==========================================================================
// bht_counter_update : 2-bit saturating up/down counter step.
// Rev 1.0
// ==========================================================================
module bht_counter_update
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ==========================================================================
// branch_predictor : bimodal 2-bit BHT direction predictor with training,
//                    mispredict pulse and statistics counters.
// Option macro BRANCH_PREDICTOR_GSHARE_EN : XOR global history into index.
// Rev 1.0
// ==========================================================================
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int GHR_W       = 6
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  branch_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [1:0]       bht_q [BHT_ENTRIES];

  logic             pred_valid_q, pred_taken_q, pred_taken_d;
  logic             mispredict_q, mispredict_d;
  logic [31:0]      branch_cnt_q, branch_cnt_d;
  logic [31:0]      mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] w_hist;
  logic [IDX_W-1:0] w_pred_idx;
  logic [IDX_W-1:0] w_train_idx;
  logic             w_train_en;
  logic [1:0]       w_train_old;
  logic [1:0]       w_train_new;
  logic             w_tbl_we;
  logic [IDX_W-1:0] w_tbl_waddr;
  logic [1:0]       w_tbl_wdata;
  logic             w_unused_pc;

  // Only the index slice of each PC participates in lookup.
  assign w_unused_pc = ^{bus.pred_pc_in[31:IDX_W+2], bus.pred_pc_in[1:0],
                         bus.res_pc_in[31:IDX_W+2],  bus.res_pc_in[1:0]};

  assign w_train_en = (state_q == RUN) && bus.res_valid_in &&
                      (bus.res_opcode_6_to_2_in == OPC_BRANCH);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (w_train_en) ghr_d = (ghr_q << 1) | GHR_W'(bus.res_taken_in);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) ghr_q <= '0;
    else           ghr_q <= ghr_d;
  end

  assign w_hist = IDX_W'(ghr_q);
`else
  assign w_hist = '0;
`endif

  assign w_pred_idx  = bus.pred_pc_in[IDX_W+1:2] ^ w_hist;
  assign w_train_idx = bus.res_pc_in[IDX_W+1:2]  ^ w_hist;
  assign w_train_old = bht_q[w_train_idx];

  bht_counter_update u_cnt_upd (
    .cnt_i   (w_train_old),
    .taken_i (bus.res_taken_in),
    .cnt_o   (w_train_new)
  );

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == IDX_W'(BHT_ENTRIES - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // The init sweep owns the write port until the table is fully seeded.
  always_comb begin
    w_tbl_we    = 1'b0;
    w_tbl_waddr = w_train_idx;
    w_tbl_wdata = w_train_new;
    if (state_q == INIT) begin
      w_tbl_we    = 1'b1;
      w_tbl_waddr = sweep_q;
      w_tbl_wdata = WNT;
    end else if (w_train_en) begin
      w_tbl_we    = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_tbl_we) bht_q[w_tbl_waddr] <= w_tbl_wdata;
  end

  always_comb begin
    pred_taken_d = 1'b0;
    if (bus.pred_req_in && (state_q == RUN)) begin
      if (bus.pred_opcode_6_to_2_in == OPC_BRANCH)
        pred_taken_d = bht_q[w_pred_idx][1];
      else if (is_jump(bus.pred_opcode_6_to_2_in))
        pred_taken_d = 1'b1;
    end
  end

  assign mispredict_d  = bus.res_valid_in && (bus.res_taken_in != bus.res_pred_taken_in);
  assign branch_cnt_d  = w_train_en   ? sat_inc32(branch_cnt_q)  : branch_cnt_q;
  assign mispred_cnt_d = mispredict_d ? sat_inc32(mispred_cnt_q) : mispred_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= INIT;
      sweep_q       <= '0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      mispredict_q  <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      pred_valid_q  <= bus.pred_req_in;
      pred_taken_q  <= pred_taken_d;
      mispredict_q  <= mispredict_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.pred_valid_out       = pred_valid_q;
  assign bus.pred_taken_out       = pred_taken_q;
  assign bus.mispredict_out       = mispredict_q;
  assign bus.ready_out            = (state_q == RUN);
  assign bus.branch_count_out     = branch_cnt_q;
  assign bus.mispredict_count_out = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ==========================================================================
// tb_branch_predictor : scoreboard bench with a reference predictor model.
// Rev 1.0
// ==========================================================================
module tb_branch_predictor;

  localparam int N = 64;
  localparam logic [4:0] BR   = 5'b11000;
  localparam logic [4:0] JAL  = 5'b11011;
  localparam logic [4:0] JALR = 5'b11001;
  localparam logic [4:0] ALU  = 5'b01100;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if bus ();

  branch_predictor #(.BHT_ENTRIES(N), .GHR_W(6)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: counter values 0..3 per entry, history, statistics.
  int mtab [N];
  int ghr;
  int bcount;
  int mcount;
  int init_left;
  bit exp_taken_q [$];
  int exp_mcnt_q  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void reset_model();
    foreach (mtab[i]) mtab[i] = 1;
    ghr       = 0;
    bcount    = 0;
    mcount    = 0;
    init_left = N;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) & (N - 1));
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    i = i ^ ghr;
`endif
    return i;
  endfunction

  task automatic set_idle();
    bus.pred_req_in           = 1'b0;
    bus.pred_pc_in            = 32'h0;
    bus.pred_opcode_6_to_2_in = 5'h0;
    bus.res_valid_in          = 1'b0;
    bus.res_pc_in             = 32'h0;
    bus.res_opcode_6_to_2_in  = 5'h0;
    bus.res_taken_in          = 1'b0;
    bus.res_pred_taken_in     = 1'b0;
  endtask

  // One clock of stimulus; expectations are pushed before the edge they describe.
  task automatic cycle(input bit req, input logic [31:0] pc, input logic [4:0] opc,
                       input bit rv, input logic [31:0] rpc, input logic [4:0] ropc,
                       input bit rt, input bit rpt);
    bit in_init;
    bit t;
    int k;
    in_init = (init_left > 0);
    bus.pred_req_in           = req;
    bus.pred_pc_in            = pc;
    bus.pred_opcode_6_to_2_in = opc;
    bus.res_valid_in          = rv;
    bus.res_pc_in             = rpc;
    bus.res_opcode_6_to_2_in  = ropc;
    bus.res_taken_in          = rt;
    bus.res_pred_taken_in     = rpt;
    if (req) begin
      if (in_init)        t = 1'b0;
      else if (opc == BR) t = (mtab[idx_of(pc)] >= 2);
      else                t = (opc == JAL) || (opc == JALR);
      exp_taken_q.push_back(t);
    end
    if (rv && (rt != rpt)) begin
      mcount++;
      exp_mcnt_q.push_back(mcount);
    end
    if (!in_init && rv && (ropc == BR)) begin
      k = idx_of(rpc);
      if (rt) begin
        if (mtab[k] < 3) mtab[k]++;
      end else begin
        if (mtab[k] > 0) mtab[k]--;
      end
      bcount++;
      ghr = ((ghr << 1) | int'(rt)) & 63;
    end
    if (in_init) init_left--;
    @(negedge clk);
    #1;
  endtask

  task automatic idle1();
    cycle(1'b0, 32'h0, 5'h0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r      = $urandom;
    r[1:0] = 2'b00;
    r[7:2] = 6'($urandom_range(0, 7));
    return r;
  endfunction

  function automatic logic [4:0] rand_opc();
    case ($urandom_range(0, 5))
      0, 1, 2: return BR;
      3:       return JAL;
      4:       return JALR;
      default: return ALU;
    endcase
  endfunction

  task automatic rand_cycle();
    cycle(bit'($urandom_range(0, 1)), rand_pc(), rand_opc(),
          bit'($urandom_range(0, 1)), rand_pc(), rand_opc(),
          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
  endtask

  // Monitor: every output event consumes one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.pred_valid_out) begin
        if (exp_taken_q.size() == 0) check("pred_valid_unexpected", bus.pred_valid_out, 0);
        else                         check("pred_taken", bus.pred_taken_out, exp_taken_q.pop_front());
      end
      if (bus.mispredict_out) begin
        if (exp_mcnt_q.size() == 0) check("mispredict_unexpected", bus.mispredict_out, 0);
        else                        check("mispredict_count", bus.mispredict_count_out, exp_mcnt_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    set_idle();
    reset_model();
    #2 rst_n = 1'b0;
    #1;
    check("rst_pred_valid", bus.pred_valid_out, 0);
    check("rst_pred_taken", bus.pred_taken_out, 0);
    check("rst_mispredict", bus.mispredict_out, 0);
    check("rst_ready", bus.ready_out, 0);
    check("rst_branch_count", bus.branch_count_out, 0);
    check("rst_mispredict_count", bus.mispredict_count_out, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Init sweep: ready low for 64 cycles; jumps predict not-taken; no training.
    for (int c = 1; c <= N; c++) begin
      check("ready_low_in_init", bus.ready_out, 0);
      if (c == 10)      cycle(1'b1, 32'h300, JAL, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
      else if (c == 20) cycle(1'b0, 32'h0, 5'h0, 1'b1, 32'h300, JAL, 1'b1, 1'b0);
      else if (c == 30) cycle(1'b1, 32'h100, BR, 1'b1, 32'h100, BR, 1'b1, 1'b1);
      else              idle1();
    end
    check("ready_after_init", bus.ready_out, 1);
    check("branch_count_after_init", bus.branch_count_out, 0);

    // Train 0x100 taken three times: 01 -> 10 -> 11 -> 11.
    cycle(1'b1, 32'h100, BR, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 5'h0, 1'b1, 32'h100, BR, 1'b1, 1'b1);
    cycle(1'b1, 32'h100, BR, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
    check("branch_count_3", bus.branch_count_out, bcount);

    // Back-to-back mispredicts also walk the counter back to weakly not-taken.
    repeat (2) cycle(1'b0, 32'h0, 5'h0, 1'b1, 32'h100, BR, 1'b0, 1'b1);
    idle1();
    check("mispredict_count_b2b", bus.mispredict_count_out, mcount);
    check("mispredict_low_after", bus.mispredict_out, 0);

    // Same-cycle read/write: read sees pre-write value.
    cycle(1'b1, 32'h200, BR, 1'b1, 32'h200, BR, 1'b1, 1'b1);
    cycle(1'b1, 32'h200, BR, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);

    // Jumps in RUN predict taken and never train.
    cycle(1'b1, 32'h300, JAL, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h304, JALR, 1'b1, 32'h300, JAL, 1'b1, 1'b1);
    cycle(1'b1, 32'h300, BR, 1'b1, 32'h300, ALU, 1'b0, 1'b0);
    check("branch_count_jump", bus.branch_count_out, bcount);

    repeat (400) rand_cycle();
    set_idle();
    idle1();
    check("branch_count_random", bus.branch_count_out, bcount);
    check("mispredict_count_random", bus.mispredict_count_out, mcount);

    // Reset in the middle of the sweep at index 20.
    rst_n = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (c < 20) rand_cycle();
      else        cycle(1'b1, 32'h40, BR, 1'b1, 32'h40, BR, 1'b0, 1'b1);
    end
    check("valid_before_reset", bus.pred_valid_out, 1);
    check("mispredict_before_reset", bus.mispredict_out, 1);
    set_idle();
    rst_n = 1'b0;
    #1;
    check("midinit_pred_valid", bus.pred_valid_out, 0);
    check("midinit_mispredict", bus.mispredict_out, 0);
    check("midinit_ready", bus.ready_out, 0);
    check("midinit_mispredict_count", bus.mispredict_count_out, 0);
    check("midinit_branch_count", bus.branch_count_out, 0);
    reset_model();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int c = 1; c <= N; c++) begin
      check("ready_low_in_reinit", bus.ready_out, 0);
      rand_cycle();
    end
    check("ready_after_reinit", bus.ready_out, 1);
    repeat (100) rand_cycle();

    set_idle();
    repeat (3) idle1();
    check("branch_count_final", bus.branch_count_out, bcount);
    check("mispredict_count_final", bus.mispredict_count_out, mcount);
    check("pred_queue_drained", exp_taken_q.size(), 0);
    check("mispredict_queue_drained", exp_mcnt_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
